fpu_mul_sched: RTL

FPU_MUL_SCHED -- requirements
Module: fpu_mul_sched

---
 rtl/fpu_pkg.sv | 19 +
 rtl/fpu_mul.sv | 134 +++++++++++++
 rtl/fpu_mul_sched.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the single-precision multiplier and its scheduler.
//   LAT_MUL    issue-to-result latency of fpu_mul, in cycles
//   fp32_t     32-bit IEEE-754 single-precision word
//   tag_width  width of a {valid, index} tag for a given number of requesters
// ---------------------------------------------------------------------------
package fpu_pkg;

  localparam int LAT_MUL = 3;

  typedef logic [31:0] fp32_t;

  // One valid bit plus enough index bits to name any requester.
  function automatic int tag_width(input int nreq);
    return 1 + ((nreq > 1) ? $clog2(nreq) : 1);
  endfunction

endpackage

// File: rtl/fpu_mul.sv
// ---------------------------------------------------------------------------
// fpu_mul
// Three-stage pipelined IEEE-754 single-precision multiplier.
// Stage 1 captures operands (only when en_i is high), stage 2 classifies the
// operands and forms the 48-bit significand product, stage 3 normalises,
// rounds to nearest-even and packs. Back stages advance every cycle.
// Subnormal inputs and results are flushed to signed zero; any NaN input
// produces the canonical quiet NaN 0x7FC00000.
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset
//   en_i    operand capture enable
//   a_i     operand A
//   b_i     operand B
//   z_o     product, LAT_MUL cycles after capture
// ---------------------------------------------------------------------------
module fpu_mul
  import fpu_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  en_i,
  input  fp32_t a_i,
  input  fp32_t b_i,
  output fp32_t z_o
);

  // Stage 1: operand capture
  fp32_t a_q, b_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_q <= '0;
      b_q <= '0;
    end else if (en_i) begin
      a_q <= a_i;
      b_q <= b_i;
    end
  end

  // Stage 2: classify and multiply significands
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic sign_d, nan_d, inf_d, zero_d;
  logic signed [9:0] exp_d;
  logic [47:0] prod_d;

  assign a_zero = (a_q[30:23] == 8'd0);
  assign b_zero = (b_q[30:23] == 8'd0);
  assign a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);

  assign sign_d = a_q[31] ^ b_q[31];
  // inf * 0 is invalid and yields NaN like a NaN input does
  assign nan_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
  assign inf_d  = a_inf | b_inf;
  assign zero_d = a_zero | b_zero;
  assign exp_d  = signed'({2'b00, a_q[30:23]}) + signed'({2'b00, b_q[30:23]}) - 10'sd127;
  assign prod_d = {24'd0, 1'b1, a_q[22:0]} * {24'd0, 1'b1, b_q[22:0]};

  logic sign_q, nan_q, inf_q, zero_q;
  logic signed [9:0] exp_q;
  logic [47:0] prod_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sign_q <= 1'b0;
      nan_q  <= 1'b0;
      inf_q  <= 1'b0;
      zero_q <= 1'b0;
      exp_q  <= '0;
      prod_q <= '0;
    end else begin
      sign_q <= sign_d;
      nan_q  <= nan_d;
      inf_q  <= inf_d;
      zero_q <= zero_d;
      exp_q  <= exp_d;
      prod_q <= prod_d;
    end
  end

  // Stage 3: normalise, round to nearest-even, pack
  logic [22:0] mant;
  logic        guard, sticky, rnd;
  logic [23:0] mant_r;
  logic signed [9:0] exp_n, exp_f;
  fp32_t z_d, z_q;

  always_comb begin
    // Product of two [1,2) significands lies in [1,4): one-bit normalise.
    if (prod_q[47]) begin
      mant   = prod_q[46:24];
      guard  = prod_q[23];
      sticky = |prod_q[22:0];
      exp_n  = exp_q + 10'sd1;
    end else begin
      mant   = prod_q[45:23];
      guard  = prod_q[22];
      sticky = |prod_q[21:0];
      exp_n  = exp_q;
    end
    rnd    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {23'd0, rnd};
    // Rounding carry-out leaves the fraction at zero and bumps the exponent.
    exp_f  = exp_n + (mant_r[23] ? 10'sd1 : 10'sd0);

    if (nan_q) begin
      z_d = 32'h7FC0_0000;
    end else if (inf_q) begin
      z_d = {sign_q, 8'hFF, 23'd0};
    end else if (zero_q) begin
      z_d = {sign_q, 31'd0};
    end else if (exp_f >= 10'sd255) begin
      z_d = {sign_q, 8'hFF, 23'd0};
    end else if (exp_f <= 10'sd0) begin
      z_d = {sign_q, 31'd0};
    end else begin
      z_d = {sign_q, exp_f[7:0], mant_r[22:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      z_q <= '0;
    end else begin
      z_q <= z_d;
    end
  end

  assign z_o = z_q;

endmodule

// File: rtl/fpu_mul_sched.sv
// ---------------------------------------------------------------------------
// fpu_mul_sched
// Round-robin scheduler sharing one pipelined fpu_mul among NREQ requesters.
// One operand pair is accepted per cycle; a tag pipeline matching the
// multiplier latency routes each product back to its requester.
// Ports:
//   clk_i         clock
//   rst_ni        synchronous active-low reset (also resets the multiplier)
//   flush_i       discard every in-flight operation, accept nothing this cycle
//   req_valid_i   per-requester operand pair pending
//   req_a_i       operand A, requester i at [32i+31:32i]
//   req_b_i       operand B, same packing
//   req_ready_o   one-hot grant (operands accepted this cycle) or zero
//   rsp_valid_o   one-hot owner of rsp_z_o this cycle or zero
//   rsp_z_o       product from the shared multiplier
//   busy_o        at least one operation in flight
// ---------------------------------------------------------------------------
module fpu_mul_sched
  import fpu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = LAT_MUL
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ*32-1:0] req_a_i,
  input  logic [NREQ*32-1:0] req_b_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [NREQ-1:0]   rsp_valid_o,
  output fp32_t             rsp_z_o,
  output logic              busy_o
);

  localparam int IW = tag_width(NREQ) - 1;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] index;
  } tag_t;

  if (LAT != LAT_MUL) begin : g_lat_check
    $error("fpu_mul_sched: LAT must equal the fpu_mul latency");
  end

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand [NREQ];
  fp32_t         a_arr [NREQ];
  fp32_t         b_arr [NREQ];
  logic [IW-1:0] grant_idx;
  logic          grant_found;
  logic          xfer;

  // cand[k] is the (k+1)-th index searched after the last winner.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign cand[gi]  = IW'((int'(ptr_q) + gi + 1) % NREQ);
    assign a_arr[gi] = req_a_i[gi*32 +: 32];
    assign b_arr[gi] = req_b_i[gi*32 +: 32];
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && req_valid_i[cand[k]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[k];
      end
    end
  end

  // A pending request is left untouched while reset or flush is asserted.
  assign xfer  = grant_found & rst_ni & ~flush_i;
  assign ptr_d = xfer ? grant_idx : ptr_q;

  always_comb begin
    req_ready_o = '0;
    if (xfer) req_ready_o[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= IW'(NREQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Tag pipeline: never stalls, mirrors the multiplier's back stages.
  tag_t tag_d;
  tag_t tag_q [LAT];

  assign tag_d = '{valid: xfer, index: grant_idx};

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  fpu_mul u_mul (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (xfer),
    .a_i   (a_arr[grant_idx]),
    .b_i   (b_arr[grant_idx]),
    .z_o   (rsp_z_o)
  );

  // Gated by reset so nothing leaks out while reset is held.
  always_comb begin
    rsp_valid_o = '0;
    if (rst_ni && tag_q[LAT-1].valid) rsp_valid_o[tag_q[LAT-1].index] = 1'b1;
  end

  logic busy_any;
  always_comb begin
    busy_any = 1'b0;
    for (int k = 0; k < LAT; k++) busy_any = busy_any | tag_q[k].valid;
  end

  assign busy_o = rst_ni & busy_any;

endmodule
